// File: rtl/imem_responder_if.sv
// Fetch bus between an instruction requester (master) and imem_responder (slave).
// Signals:
//   imem_req / imem_addr : single-cycle line request strobe and byte address.
//   imem_rdata / imem_resp : returned line and one-cycle response pulse.
//   oor_err : pulses with imem_resp when the request was out of range.
//   proto_err : sticky flag for a request issued while a response is still outstanding.
interface imem_responder_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned BUS_WID = 128
);
    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic [BUS_WID-1:0] imem_rdata;
    logic               imem_resp;
    logic               oor_err;
    logic               proto_err;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_resp, oor_err, proto_err
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_resp, oor_err, proto_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed instruction array serving one line
// request at a time, with the line returned LATENCY cycles after acceptance.
// A side load port writes 32-bit words at any time, independent of fetch state.
// Ports:
//   clk       : clock, all state on rising edge
//   rst       : synchronous active-high reset (array contents are kept)
//   bus       : fetch bus, slave side (req/addr in, rdata/resp/oor_err/proto_err out)
//   load_we   : load-port word write enable
//   load_addr : load byte address, bits [1:0] ignored
//   load_data : load word
module imem_responder #(
    parameter int unsigned      XLEN        = 32,
    parameter int unsigned      BUS_LEN     = 4,
    parameter logic [XLEN-1:0]  BASE_ADDR   = '0,
    parameter int unsigned      DEPTH_WORDS = 4096,
    parameter int unsigned      LATENCY     = 2
) (
    input  logic                clk,
    input  logic                rst,
    imem_responder_if.slave     bus,
    input  logic                load_we,
    input  logic [XLEN-1:0]     load_addr,
    input  logic [31:0]         load_data
);

    localparam int unsigned BUS_WID    = 32 * BUS_LEN;
    localparam int unsigned LINE_BYTES = 4 * BUS_LEN;
    localparam int unsigned IW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [XLEN-1:0] ARRAY_BYTES = XLEN'(4 * DEPTH_WORDS);
    localparam logic [XLEN-1:0] LINE_MASK   = ~XLEN'(LINE_BYTES - 1);
    localparam logic [XLEN-1:0] WORD_MASK   = ~XLEN'(3);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               resp_q, resp_d;
    logic [BUS_WID-1:0] rdata_q, rdata_d;
    logic               oor_q, oor_d;
    logic               proto_q, proto_d;
    logic [BUS_WID-1:0] line_q, line_d;
    logic               line_oor_q, line_oor_d;

    // Request decode: line-align, offset from base, range check, word index.
    logic [XLEN-1:0]    req_line;
    logic [XLEN-1:0]    req_off;
    logic               req_in_range;
    logic [IW-1:0]      req_idx;
    logic [BUS_WID-1:0] rd_line;
    logic [BUS_WID-1:0] snap_line;

    always_comb begin
        req_line     = bus.imem_addr & LINE_MASK;
        req_off      = req_line - BASE_ADDR;
        req_in_range = (req_line >= BASE_ADDR) &&
                       ((req_off + XLEN'(LINE_BYTES)) <= ARRAY_BYTES);
        req_idx      = IW'(req_off >> 2);
    end

    // Line read, word k at bits [32k +: 32], lowest address in word 0.
    always_comb begin
        rd_line = '0;
        for (int k = 0; k < int'(BUS_LEN); k++) begin
            rd_line[32*k +: 32] = mem[req_idx + IW'(k)];
        end
        snap_line = req_in_range ? rd_line : '0;
    end

    // Load decode: word-align, range check; out-of-range writes are dropped.
    logic [XLEN-1:0] ld_word;
    logic [XLEN-1:0] ld_off;
    logic            ld_in_range;
    logic [IW-1:0]   ld_idx;

    always_comb begin
        ld_word     = load_addr & WORD_MASK;
        ld_off      = ld_word - BASE_ADDR;
        ld_in_range = (ld_word >= BASE_ADDR) && ((ld_off + XLEN'(4)) <= ARRAY_BYTES);
        ld_idx      = IW'(ld_off >> 2);
    end

    // Array write; a same-edge fetch snapshot sees the old word.
    always_ff @(posedge clk) begin
        if (load_we && ld_in_range) begin
            mem[ld_idx] <= load_data;
        end
    end

    // Request acceptance: idle, or back-to-back in the response cycle.
    logic accept;
    logic violation;

    always_comb begin
        accept    = bus.imem_req && ((state_q == ST_IDLE) || resp_q);
        violation = bus.imem_req && (state_q == ST_BUSY) && !resp_q;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        resp_d     = 1'b0;
        rdata_d    = rdata_q;
        oor_d      = 1'b0;
        proto_d    = proto_q;
        line_d     = line_q;
        line_oor_d = line_oor_q;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            state_d    = ST_BUSY;
            cnt_d      = CW'(LATENCY - 1);
            line_d     = snap_line;
            line_oor_d = !req_in_range;
        end

        // Response is launched one edge early so it is visible exactly LATENCY cycles after accept.
        if (LATENCY == 1) begin
            if (accept) begin
                resp_d  = 1'b1;
                rdata_d = snap_line;
                oor_d   = !req_in_range;
            end
        end else if ((state_q == ST_BUSY) && (cnt_q == CW'(1))) begin
            resp_d  = 1'b1;
            rdata_d = line_q;
            oor_d   = line_oor_q;
        end

        if (violation) begin
            proto_d = 1'b1;
        end
    end

    // State and output registers; a pending response is dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            resp_q     <= 1'b0;
            rdata_q    <= '0;
            oor_q      <= 1'b0;
            proto_q    <= 1'b0;
            line_q     <= '0;
            line_oor_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            resp_q     <= resp_d;
            rdata_q    <= rdata_d;
            oor_q      <= oor_d;
            proto_q    <= proto_d;
            line_q     <= line_d;
            line_oor_q <= line_oor_d;
        end
    end

    assign bus.imem_resp  = resp_q;
    assign bus.imem_rdata = rdata_q;
    assign bus.oor_err    = oor_q;
    assign bus.proto_err  = proto_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (LATENCY 1, 2, 3; BASE 0, DEPTH 4096,
// BUS_LEN 4) share clock, reset and load port; each has its own fetch bus.
// A flat word-array model plus per-instance "pending response due at cycle N"
// bookkeeping predicts resp/rdata/oor_err/proto_err every cycle.
module tb_imem_responder;

    localparam int unsigned DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    logic [2:0]   req;
    logic [31:0]  addr [3];
    logic [127:0] rdata_o [3];
    logic [2:0]   resp_o;
    logic [2:0]   oor_o;
    logic [2:0]   proto_o;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        imem_responder_if #(.XLEN(32), .BUS_WID(128)) bus ();

        imem_responder #(
            .XLEN(32), .BUS_LEN(4), .BASE_ADDR(32'h0),
            .DEPTH_WORDS(DEPTH), .LATENCY(g + 1)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .bus       (bus),
            .load_we   (load_we),
            .load_addr (load_addr),
            .load_data (load_data)
        );

        assign bus.imem_req  = req[g];
        assign bus.imem_addr = addr[g];
        assign rdata_o[g]    = bus.imem_rdata;
        assign resp_o[g]     = bus.imem_resp;
        assign oor_o[g]      = bus.oor_err;
        assign proto_o[g]    = bus.proto_err;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0]  mref [DEPTH];
    bit           pend_v    [3];
    int           pend_c    [3];
    logic [127:0] pend_line [3];
    bit           pend_oor  [3];
    bit           proto_m   [3];
    logic [127:0] last_m    [3];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Expected line for a byte address: {out_of_range, line}.
    function automatic logic [128:0] model_line(input logic [31:0] a);
        logic [31:0]  base;
        logic [127:0] l;
        base = a & ~32'hF;
        l    = '0;
        if (base >= 32'(4 * DEPTH)) return {1'b1, 128'h0};
        for (int k = 0; k < 4; k++) l[32*k +: 32] = mref[(base >> 2) + 32'(k)];
        return {1'b0, l};
    endfunction

    // One cycle: check outputs against the model, drive inputs, advance the model.
    task automatic step(input logic [2:0] rq, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] a2, input bit lw, input logic [31:0] la,
                        input logic [31:0] ld, input bit do_rst);
        logic [31:0]  a [3];
        logic [128:0] ml;
        bit           er;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            er = pend_v[i] && (pend_c[i] == cyc);
            if (er) last_m[i] = pend_line[i];
            chk($sformatf("resp[%0d]@%0d", i, cyc), 128'(resp_o[i]), 128'(er));
            chk($sformatf("rdata[%0d]@%0d", i, cyc), rdata_o[i], last_m[i]);
            chk($sformatf("oor[%0d]@%0d", i, cyc), 128'(oor_o[i]), 128'(er && pend_oor[i]));
            chk($sformatf("proto[%0d]@%0d", i, cyc), 128'(proto_o[i]), 128'(proto_m[i]));
        end
        a[0] = a0; a[1] = a1; a[2] = a2;
        rst       = do_rst;
        req       = rq;
        addr[0]   = a0; addr[1] = a1; addr[2] = a2;
        load_we   = lw;
        load_addr = la;
        load_data = ld;
        if (do_rst) begin
            for (int i = 0; i < 3; i++) begin
                pend_v[i] = 1'b0; proto_m[i] = 1'b0; last_m[i] = '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (rq[i]) begin
                    if (!pend_v[i] || pend_c[i] <= cyc) begin
                        ml           = model_line(a[i]);
                        pend_v[i]    = 1'b1;
                        pend_c[i]    = cyc + i + 1;
                        pend_oor[i]  = ml[128];
                        pend_line[i] = ml[127:0];
                    end else begin
                        proto_m[i] = 1'b1;
                    end
                end
            end
        end
        if (lw && la < 32'(4 * DEPTH)) mref[la >> 2] = ld;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(3'b000, 0, 0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic rst_cycles(input int n);
        for (int j = 0; j < n; j++) step(3'b000, 0, 0, 0, 1'b0, 0, 0, 1'b1);
    endtask

    initial begin
        logic [2:0]  rq;
        logic [31:0] ra [3];
        bit          lw;
        logic [31:0] la;
        logic [127:0] t;

        rst = 1'b1; req = '0; load_we = 1'b0; load_addr = '0; load_data = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; pend_v[i] = 1'b0; pend_c[i] = 0; pend_line[i] = '0;
            pend_oor[i] = 1'b0; proto_m[i] = 1'b0; last_m[i] = '0;
        end
        for (int w = 0; w < int'(DEPTH); w++) mref[w] = '0;

        rst_cycles(3);

        // Fill the array; low address bits are noise that must be ignored.
        for (int w = 0; w < int'(DEPTH); w++)
            step(3'b000, 0, 0, 0, 1'b1, 32'(w * 4) | 32'($urandom_range(0, 3)), $urandom, 1'b0);
        step(3'b000, 0, 0, 0, 1'b1, 32'h200, 32'h11, 1'b0);
        step(3'b000, 0, 0, 0, 1'b1, 32'h204, 32'h22, 1'b0);
        step(3'b000, 0, 0, 0, 1'b1, 32'h208, 32'h33, 1'b0);
        step(3'b000, 0, 0, 0, 1'b1, 32'h20C, 32'h44, 1'b0);

        // LAT 2: response only two cycles after accept, known line content.
        step(3'b010, 0, 32'h200, 0, 1'b0, 0, 0, 1'b0);
        idle(1);
        chk("t1_no_early_resp", 128'(resp_o[1]), 128'h0);
        idle(1);
        chk("t1_resp", 128'(resp_o[1]), 128'h1);
        chk("t1_line", rdata_o[1], 128'h00000044_00000033_00000022_00000011);
        idle(1);

        // LAT 1: three consecutive requests, three consecutive responses.
        step(3'b001, 32'h200, 0, 0, 1'b0, 0, 0, 1'b0);
        step(3'b001, 32'h210, 0, 0, 1'b0, 0, 0, 1'b0);
        chk("t2_first_line", rdata_o[0], 128'h00000044_00000033_00000022_00000011);
        step(3'b001, 32'h220, 0, 0, 1'b0, 0, 0, 1'b0);
        idle(2);
        chk("t2_proto", 128'(proto_o[0]), 128'h0);

        // LAT 2: request while busy is ignored and sets sticky proto_err.
        step(3'b010, 0, 32'h200, 0, 1'b0, 0, 0, 1'b0);
        step(3'b010, 0, 32'h210, 0, 1'b0, 0, 0, 1'b0);
        idle(1);
        chk("t3_resp", 128'(resp_o[1]), 128'h1);
        chk("t3_line", rdata_o[1], 128'h00000044_00000033_00000022_00000011);
        chk("t3_proto", 128'(proto_o[1]), 128'h1);
        idle(3);
        chk("t3_proto_sticky", 128'(proto_o[1]), 128'h1);
        rst_cycles(1);

        // Out-of-range request and dropped out-of-range load; last in-range line.
        step(3'b111, 32'h4000, 32'h4000, 32'h4000, 1'b1, 32'h4000, 32'hBAD0BAD0, 1'b0);
        idle(1);
        chk("t4_oor_lat1", 128'(oor_o[0]), 128'h1);
        chk("t4_zero_lat1", rdata_o[0], 128'h0);
        step(3'b111, 32'h0, 32'h3FF0, 32'h3FFC, 1'b0, 0, 0, 1'b0);
        idle(4);

        // Same-cycle load and accept: old word returned, new word next time.
        step(3'b010, 0, 32'h200, 0, 1'b1, 32'h200, 32'hDEAD, 1'b0);
        idle(2);
        t = rdata_o[1];
        chk("t5_old_word", {96'h0, t[31:0]}, 128'h11);
        step(3'b010, 0, 32'h200, 0, 1'b0, 0, 0, 1'b0);
        idle(2);
        t = rdata_o[1];
        chk("t5_new_word", {96'h0, t[31:0]}, 128'hDEAD);

        // LAT 3: reset one cycle after accept discards the response.
        idle(1);
        step(3'b100, 0, 0, 32'h200, 1'b0, 0, 0, 1'b0);
        rst_cycles(1);
        idle(3);
        chk("t6_no_resp", 128'(resp_o[2]), 128'h0);
        chk("t6_rdata_zero", rdata_o[2], 128'h0);
        step(3'b100, 0, 0, 32'h200, 1'b0, 0, 0, 1'b0);
        idle(3);
        t = rdata_o[2];
        chk("t6_after_reset", {96'h0, t[31:0]}, 128'hDEAD);

        // Random traffic: mostly legal requests, rare violations, loads and resets.
        for (int n = 0; n < 3000; n++) begin
            rq = '0;
            for (int i = 0; i < 3; i++) begin
                int r;
                r     = int'($urandom_range(0, 99));
                ra[i] = 32'($urandom_range(0, 32'h44FF));
                if (!pend_v[i] || pend_c[i] <= cyc) rq[i] = (r < 50);
                else                               rq[i] = (r < 3);
            end
            lw = ($urandom_range(0, 99) < 30);
            la = 32'($urandom_range(0, 32'h47FF));
            if ($urandom_range(0, 199) == 0)
                step(3'b000, 0, 0, 0, 1'b0, 0, 0, 1'b1);
            else
                step(rq, ra[0], ra[1], ra[2], lw, la, $urandom, 1'b0);
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
